id_issue_buffer: RTL and testbench



---
 rtl/id_issue_buffer.sv | 181 ++++++++++++++++++
 tb/tb_id_issue_buffer.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/id_issue_buffer.sv
// id_issue_buffer: decode-to-issue buffer built as an in-order circular queue.
// Decode pushes up to NR_IN_PORTS entries per cycle, issue sees the oldest
// NR_OUT_PORTS entries and retires them with per-port acks. A flush empties
// the queue in one cycle.
// Optional build macro ID_ISSUE_BUFFER_BYPASS_EN: when the queue is empty,
// accepted inputs are forwarded combinationally to the outputs in the same
// cycle. Without the macro, outputs come only from registered state.
module id_issue_buffer #(
   parameter int NR_IN_PORTS  = 2,
   parameter int NR_OUT_PORTS = 2,
   parameter int DEPTH        = 4,
   parameter int DATA_W       = 64
) (
   input  logic                             clk_i,
   input  logic                             rst_ni,
   input  logic                             flush_i,
   input  logic [NR_IN_PORTS*DATA_W-1:0]    in_data_i,
   input  logic [NR_IN_PORTS-1:0]           in_valid_i,
   output logic [NR_IN_PORTS-1:0]           in_ready_o,
   output logic [NR_OUT_PORTS*DATA_W-1:0]   out_data_o,
   output logic [NR_OUT_PORTS-1:0]          out_valid_o,
   input  logic [NR_OUT_PORTS-1:0]          out_ack_i,
   output logic [$clog2(DEPTH+1)-1:0]       count_o
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH+1);
   // One extra bit so DEPTH + n_ack cannot overflow.
   localparam int NW = CW + 1;

   logic [DATA_W-1:0]       mem [DEPTH];
   logic [PW-1:0]           rd_ptr;
   logic [PW-1:0]           wr_ptr;
   logic [CW-1:0]           count;

   logic [NR_OUT_PORTS-1:0] q_valid;
   logic [NW-1:0]           n_ack_q;
   logic [NW-1:0]           n_ack;
   logic [NW-1:0]           n_acc;
   logic [NW-1:0]           n_skip;
   logic [NW-1:0]           free;
   logic [NR_IN_PORTS-1:0]  ready;
   logic [NR_IN_PORTS-1:0]  acc_mask;
   logic [NW-1:0]           count_nxt;

   // Pointer advance modulo DEPTH (also correct for DEPTH == 1).
   function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input int n);
      int s;
      s = (int'(p) + n) % DEPTH;
      return PW'(s);
   endfunction

   // Registered valids and the ack run they allow; this drives free space
   // without looping through any bypass path.
   always_comb begin : q_ack_run
      logic run;
      q_valid = '0;
      n_ack_q = '0;
      run     = 1'b1;
      for (int j = 0; j < NR_OUT_PORTS; j++) begin
         q_valid[j] = (NW'(count) > NW'(j));
         if (run && out_ack_i[j] && q_valid[j]) begin
            n_ack_q = n_ack_q + NW'(1);
         end else begin
            run = 1'b0;
         end
      end
   end

   // Free space includes slots issue releases this cycle, so a full queue
   // can accept on the same cycle it is drained.
   always_comb begin : accept_run
      logic run;
      free     = NW'(DEPTH) - NW'(count) + n_ack_q;
      ready    = '0;
      acc_mask = '0;
      n_acc    = '0;
      run      = 1'b1;
      for (int i = 0; i < NR_IN_PORTS; i++) begin
         ready[i] = (free > NW'(i)) && !flush_i && rst_ni;
         if (run && in_valid_i[i] && ready[i]) begin
            n_acc       = n_acc + NW'(1);
            acc_mask[i] = 1'b1;
         end else begin
            run = 1'b0;
         end
      end
   end

   assign in_ready_o = ready;

`ifdef ID_ISSUE_BUFFER_BYPASS_EN
   localparam int NB = (NR_OUT_PORTS < NR_IN_PORTS) ? NR_OUT_PORTS : NR_IN_PORTS;
   logic byp_act;
   assign byp_act = (count == '0) && !flush_i;
`endif

   // Output selection: oldest queued entries, zero where not valid; an
   // empty queue may forward accepted inputs when bypass is built in.
   always_comb begin : out_sel
      out_valid_o = q_valid;
      out_data_o  = '0;
      for (int j = 0; j < NR_OUT_PORTS; j++) begin
         if (q_valid[j]) begin
            out_data_o[j*DATA_W +: DATA_W] = mem[ptr_add(rd_ptr, j)];
         end
      end
`ifdef ID_ISSUE_BUFFER_BYPASS_EN
      if (byp_act) begin
         for (int j = 0; j < NB; j++) begin
            if (NW'(j) < n_acc) begin
               out_valid_o[j]                 = 1'b1;
               out_data_o[j*DATA_W +: DATA_W] = in_data_i[j*DATA_W +: DATA_W];
            end
         end
      end
`endif
   end

   // Ack run over what issue actually sees; acks after a gap are dropped.
   always_comb begin : ack_run
      logic run;
      n_ack = '0;
      run   = 1'b1;
      for (int j = 0; j < NR_OUT_PORTS; j++) begin
         if (run && out_ack_i[j] && out_valid_o[j]) begin
            n_ack = n_ack + NW'(1);
         end else begin
            run = 1'b0;
         end
      end
   end

   // Bypassed entries that are acked immediately never enter storage.
`ifdef ID_ISSUE_BUFFER_BYPASS_EN
   assign n_skip = byp_act ? n_ack : '0;
`else
   assign n_skip = '0;
`endif

   // Skipped entries cancel out of both terms, leaving count + acc - ack.
   assign count_nxt = NW'(count) + n_acc - n_ack;

   // Queue control state; flush and reset both clear it.
   always_ff @(posedge clk_i) begin
      if (!rst_ni || flush_i) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         rd_ptr <= ptr_add(rd_ptr, int'(n_ack) - int'(n_skip));
         wr_ptr <= ptr_add(wr_ptr, int'(n_acc) - int'(n_skip));
         count  <= CW'(count_nxt);
      end
   end

   // Payload storage, no reset; accepted entries land in order from wr_ptr.
   always_ff @(posedge clk_i) begin
      for (int i = 0; i < NR_IN_PORTS; i++) begin
         if (acc_mask[i] && (NW'(i) >= n_skip)) begin
            mem[ptr_add(wr_ptr, i - int'(n_skip))] <= in_data_i[i*DATA_W +: DATA_W];
         end
      end
   end

   assign count_o = count;

   // Acks beyond the first gap are ignored; surface them so issue bugs show.
   a_ack_gap : assert property (@(posedge clk_i) disable iff (!rst_ni)
      !flush_i |-> ($countones(out_ack_i & out_valid_o) == int'(n_ack)))
      else $warning("id_issue_buffer: ack beyond first gap ignored");

   a_count_max : assert property (@(posedge clk_i) disable iff (!rst_ni)
      int'(count) <= DEPTH)
      else $error("id_issue_buffer: occupancy above DEPTH");

   a_ptr_diff : assert property (@(posedge clk_i) disable iff (!rst_ni)
      PW'(wr_ptr - rd_ptr) == PW'(int'(count) % DEPTH))
      else $error("id_issue_buffer: pointers disagree with occupancy");

endmodule

// File: tb/tb_id_issue_buffer.sv
// Directed bench for id_issue_buffer with a queue scoreboard of expected
// entries; honours ID_ISSUE_BUFFER_BYPASS_EN for same-cycle visibility.
module tb_id_issue_buffer;

   localparam int NI    = 2;
   localparam int NO    = 2;
   localparam int DEPTH = 4;
   localparam int DW    = 64;
   localparam int CW    = $clog2(DEPTH+1);

   logic              clk = 1'b0;
   logic              rst_n;
   logic              flush;
   logic [NI*DW-1:0]  in_data;
   logic [NI-1:0]     in_valid;
   logic [NI-1:0]     in_ready;
   logic [NO*DW-1:0]  out_data;
   logic [NO-1:0]     out_valid;
   logic [NO-1:0]     out_ack;
   logic [CW-1:0]     count;

   int total = 0;
   int bad   = 0;
   bit started = 1'b0;
   logic [DW-1:0] sb [$];

   always #5 clk = ~clk;

   id_issue_buffer #(
      .NR_IN_PORTS (NI),
      .NR_OUT_PORTS(NO),
      .DEPTH       (DEPTH),
      .DATA_W      (DW)
   ) dut (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .flush_i    (flush),
      .in_data_i  (in_data),
      .in_valid_i (in_valid),
      .in_ready_o (in_ready),
      .out_data_o (out_data),
      .out_valid_o(out_valid),
      .out_ack_i  (out_ack),
      .count_o    (count)
   );

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   // One clock of stimulus: model the cycle, check ready and pre-edge
   // outputs, clock it, update the scoreboard and check registered outputs.
   task automatic step(input logic r, input logic fl, input logic [NI-1:0] v,
                       input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                       input logic [NO-1:0] ack);
      int n_ack_reg, n_ack, n_acc, free, vlim;
      logic run;
      logic [NI-1:0] exp_rdy;
      logic [DW-1:0] d [NI];
      logic [DW-1:0] exp_d;
      @(negedge clk);
      rst_n    = r;
      flush    = fl;
      in_valid = v;
      in_data  = {d1, d0};
      out_ack  = ack;
      d[0] = d0;
      d[1] = d1;

      n_ack_reg = 0;
      run = 1'b1;
      for (int j = 0; j < NO; j++)
         if (run && ack[j] && sb.size() > j) n_ack_reg++; else run = 1'b0;
      free = DEPTH - sb.size() + n_ack_reg;
      for (int i = 0; i < NI; i++) exp_rdy[i] = (free > i) && !fl && r;
      n_acc = 0;
      run = 1'b1;
      for (int i = 0; i < NI; i++)
         if (run && v[i] && exp_rdy[i]) n_acc++; else run = 1'b0;
      vlim = sb.size();
`ifdef ID_ISSUE_BUFFER_BYPASS_EN
      if (sb.size() == 0 && !fl) vlim = (n_acc < NO) ? n_acc : NO;
`endif
      n_ack = 0;
      run = 1'b1;
      for (int j = 0; j < NO; j++)
         if (run && ack[j] && vlim > j) n_ack++; else run = 1'b0;

      #1;
      chk("in_ready", in_ready, exp_rdy);
      if (started) begin
         for (int j = 0; j < NO; j++) begin
            exp_d = '0;
            if (j < sb.size()) exp_d = sb[j];
            else if (j < vlim) exp_d = d[j];
            chk($sformatf("pre_valid%0d", j), out_valid[j], vlim > j);
            chk($sformatf("pre_data%0d", j), out_data[j*DW +: DW], exp_d);
         end
      end

      @(posedge clk);
      #1;
      in_valid = '0;
      out_ack  = '0;
      flush    = 1'b0;
      if (!r || fl) begin
         sb.delete();
      end else begin
         for (int i = 0; i < n_acc; i++) sb.push_back(d[i]);
         repeat (n_ack) void'(sb.pop_front());
      end
      started = 1'b1;
      #1;
      chk("count", count, sb.size());
      for (int j = 0; j < NO; j++) begin
         exp_d = (j < sb.size()) ? sb[j] : '0;
         chk($sformatf("valid%0d", j), out_valid[j], j < sb.size());
         chk($sformatf("data%0d", j), out_data[j*DW +: DW], exp_d);
      end
   endtask

   initial begin
      rst_n = 1'b0; flush = 1'b0; in_valid = '0; in_data = '0; out_ack = '0;

      // Reset: ready held low, state clears
      step(0, 0, 2'b00, 0, 0, 2'b00);
      step(0, 0, 2'b11, 64'h11, 64'h12, 2'b00);

      // Single push after reset, then retire it
      step(1, 0, 2'b01, 64'hA, 64'h0, 2'b00);
      step(1, 0, 2'b00, 0, 0, 2'b01);

      // Fill to DEPTH, stall when full, accept one when one is acked
      step(1, 0, 2'b11, 64'hB0, 64'hB1, 2'b00);
      step(1, 0, 2'b11, 64'hB2, 64'hB3, 2'b00);
      step(1, 0, 2'b11, 64'hBE, 64'hBF, 2'b00);
      step(1, 0, 2'b11, 64'hB4, 64'hB5, 2'b01);
      step(1, 0, 2'b00, 0, 0, 2'b11);
      step(1, 0, 2'b00, 0, 0, 2'b11);

      // Ack gap leaves occupancy unchanged; valid after a gap is not taken
      step(1, 0, 2'b11, 64'hC0, 64'hC1, 2'b00);
      step(1, 0, 2'b10, 64'hCE, 64'hC2, 2'b00);
      step(1, 0, 2'b01, 64'hC2, 64'h0, 2'b00);
      step(1, 0, 2'b00, 0, 0, 2'b10);
      step(1, 0, 2'b00, 0, 0, 2'b11);
      step(1, 0, 2'b00, 0, 0, 2'b01);

      // Wrap-around: steady push one / ack one with one entry held
      step(1, 0, 2'b01, 64'hA0, 64'h0, 2'b00);
      for (int k = 1; k <= 10; k++) step(1, 0, 2'b01, 64'hA0 + 64'(k), 64'h0, 2'b01);

      // Flush with three queued plus a push and an ack in the same cycle
      step(1, 0, 2'b11, 64'hD0, 64'hD1, 2'b00);
      step(1, 1, 2'b11, 64'hF0, 64'hF1, 2'b01);
      step(1, 0, 2'b00, 0, 0, 2'b00);

      // Reset in mid-stream, then the first push lands at the head
      step(1, 0, 2'b11, 64'hE0, 64'hE1, 2'b00);
      step(0, 0, 2'b11, 64'hEE, 64'hEF, 2'b01);
      step(1, 0, 2'b01, 64'hE5, 64'h0, 2'b00);
      step(1, 0, 2'b10, 64'h0, 64'hE6, 2'b01);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
